// File: rtl/output_map_pkg.sv
// Shared definitions for the memory-mapped output port block: register map,
// access-size encoding and byte-lane helpers.
package output_map_pkg;

   // Per-channel register offsets inside the 16-byte channel window
   localparam logic [3:0]  OFS_DATA      = 4'h0;
   localparam logic [3:0]  OFS_SET       = 4'h4;
   localparam logic [3:0]  OFS_CLR       = 4'h8;
   localparam logic [3:0]  OFS_DUTY      = 4'hC;

   // Shared prescaler register, above the largest possible channel window
   localparam logic [31:0] ADDR_PRESCALE = 32'h0000_0100;

   // PWM counter runs 0..PWM_MAX, so a duty of 255 is never reached by the
   // counter and therefore means "always on"
   localparam logic [7:0]  PWM_MAX       = 8'd254;
   localparam logic [7:0]  DUTY_RST      = 8'hFF;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } size_e;

   // Byte-lane enables for an access; misaligned or reserved accesses
   // produce an all-zero mask so the write is dropped entirely
   function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] ofs);
      logic [3:0] m;
      m = 4'b0000;
      case (size)
         SZ_BYTE: m = 4'b0001 << ofs;
         SZ_HALF: if (!ofs[0]) m = ofs[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: if (ofs == 2'b00) m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Expand byte-lane enables into a 32-bit bit mask
   function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
      return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
   endfunction

endpackage

// File: rtl/output_port_map_pwm_timebase.sv
// Shared PWM timebase: programmable 16-bit prescaler that issues a one-cycle
// tick every PRESCALE+1 cycles, and an 8-bit PWM counter advanced by the tick.
module pwm_timebase
   import output_map_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ps_we,
   input  logic [15:0] i_ps_wdata,
   output logic [15:0] o_prescale,
   output logic [7:0]  o_pwm_cnt
);

   logic [15:0] r_prescale;
   logic [15:0] r_ps_cnt;
   logic [7:0]  r_pwm_cnt;
   logic        w_tick;

   // A PRESCALE write restarts the prescaler, so no tick is issued on that
   // edge and the PWM counter holds its value
   assign w_tick = (r_ps_cnt == r_prescale) && !i_ps_we;

   // Prescale register and prescaler count
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prescale <= '0;
         r_ps_cnt   <= '0;
      end else if (i_ps_we) begin
         r_prescale <= i_ps_wdata;
         r_ps_cnt   <= '0;
      end else if (w_tick) begin
         r_ps_cnt   <= '0;
      end else begin
         r_ps_cnt   <= r_ps_cnt + 16'd1;
      end
   end

   // PWM counter: 0..PWM_MAX then wrap, one step per tick
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pwm_cnt <= '0;
      end else if (w_tick) begin
         r_pwm_cnt <= (r_pwm_cnt >= PWM_MAX) ? 8'd0 : r_pwm_cnt + 8'd1;
      end
   end

   assign o_prescale = r_prescale;
   assign o_pwm_cnt  = r_pwm_cnt;

endmodule

// File: rtl/output_port_map.sv
// Memory-mapped output port: NUM_CHANNELS registers of WIDTH bits with
// set/clear aliases, byte-lane writes, read-back and per-channel PWM dimming
// from a shared timebase. The pin outputs are registered once more.
module output_port_map
   import output_map_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int WIDTH        = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [31:0]                   output_address,
   input  logic [31:0]                   output_in,
   input  logic [1:0]                    output_size,
   input  logic                          output_write_enable,
   output logic [31:0]                   output_out,
   output logic [NUM_CHANNELS*WIDTH-1:0] led
);

   // DATA bits at or above WIDTH are never stored
   localparam logic [31:0] DATA_MASK = 32'hFFFF_FFFF >> (32 - WIDTH);

   logic [3:0]  w_lanes;
   logic [31:0] w_bits;
   logic        w_wr;
   logic [3:0]  w_ofs;
   logic        w_ps_sel;
   logic        w_ps_we;
   logic [15:0] w_ps_wdata;
   logic [15:0] w_prescale;
   logic [7:0]  w_pwm_cnt;

   logic [31:0]      r_data [NUM_CHANNELS];
   logic [7:0]       r_duty [NUM_CHANNELS];
   logic [WIDTH-1:0] r_led  [NUM_CHANNELS];

   // ---------------------------------------------------------------------
   // Access decode
   // ---------------------------------------------------------------------
   assign w_lanes  = lane_mask(size_e'(output_size), output_address[1:0]);
   assign w_bits   = lane_bits(w_lanes);
   assign w_wr     = output_write_enable && (w_lanes != 4'b0000);
   assign w_ofs    = {output_address[3:2], 2'b00};
   assign w_ps_sel = (output_address[31:2] == ADDR_PRESCALE[31:2]);

   // PRESCALE is 16 bits wide; a write touching only its upper lanes is
   // not a PRESCALE write and must not restart the prescaler
   assign w_ps_we    = w_wr && w_ps_sel && (w_lanes[1:0] != 2'b00);
   assign w_ps_wdata = (w_prescale & ~w_bits[15:0]) | (output_in[15:0] & w_bits[15:0]);

   pwm_timebase u_timebase (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_ps_we    (w_ps_we),
      .i_ps_wdata (w_ps_wdata),
      .o_prescale (w_prescale),
      .o_pwm_cnt  (w_pwm_cnt)
   );

   // ---------------------------------------------------------------------
   // Per-channel registers and pin pipeline
   // ---------------------------------------------------------------------
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      logic        w_hit;
      logic [31:0] w_data_nxt;
      logic        w_pwm_on;

      assign w_hit    = w_wr && (output_address[31:4] == 28'(c));
      assign w_pwm_on = (w_pwm_cnt < r_duty[c]);

      // Next DATA value for the addressed alias, restricted to enabled lanes
      always_comb begin
         w_data_nxt = r_data[c];
         case (w_ofs)
            OFS_DATA: w_data_nxt = (r_data[c] & ~w_bits) | (output_in & w_bits);
            OFS_SET:  w_data_nxt = r_data[c] | (output_in & w_bits);
            OFS_CLR:  w_data_nxt = r_data[c] & ~(output_in & w_bits);
            default:  w_data_nxt = r_data[c];
         endcase
      end

      // DATA and DUTY registers; DUTY lives in lane 0 only
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_data[c] <= '0;
            r_duty[c] <= DUTY_RST;
         end else if (w_hit) begin
            if (w_ofs == OFS_DUTY) begin
               if (w_lanes[0]) r_duty[c] <= output_in[7:0];
            end else begin
               r_data[c] <= w_data_nxt & DATA_MASK;
            end
         end
      end

      // Pin register: gated DATA, one cycle behind the register write
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_led[c] <= '0;
         end else begin
            r_led[c] <= r_data[c][WIDTH-1:0] & {WIDTH{w_pwm_on}};
         end
      end

      assign led[c*WIDTH +: WIDTH] = r_led[c];
   end

   // ---------------------------------------------------------------------
   // Read-back mux; unmapped addresses read as zero
   // ---------------------------------------------------------------------
   // Combinational read of the register selected by the word address
   always_comb begin
      output_out = '0;
      if (w_ps_sel) output_out = {16'h0000, w_prescale};
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (output_address[31:4] == 28'(c)) begin
            if (w_ofs == OFS_DUTY) output_out = {24'h000000, r_duty[c]};
            else                   output_out = r_data[c];
         end
      end
   end

endmodule

// File: doc/output_port_map.md
# output_port_map

Parametrised memory-mapped output block for the PISA core's output space, next generation of the single-register LED port. Provides `NUM_CHANNELS` independent output registers of `WIDTH` bits. Each channel has atomic set/clear aliases, byte-lane sub-word writes, full read-back and an 8-bit PWM dimmer driven from a shared, programmable prescaler. The block sits on the core's output bus and drives board pins such as LEDs.

## Interface
Parameters:
- `NUM_CHANNELS`, 4, number of output channels (1..16)
- `WIDTH`, 8, bits per channel (1..32)

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `output_address`  in  32  byte address
- `output_in`  in  32  write data, lane-aligned to the address
- `output_size`  in  2  0=byte, 1=half, 2=word, 3=reserved (write ignored)
- `output_write_enable`  in  1  write strobe, one write per cycle
- `output_out`  out  32  read data, combinational from `output_address`
- `led`  out  `NUM_CHANNELS*WIDTH`  registered pin outputs; channel c occupies bits [c*WIDTH +: WIDTH]

## Operation
- Channel c register window at `0x10*c`:
  - +0x0 DATA: read/write.
  - +0x4 SET: writing ORs the value into DATA; reads return DATA.
  - +0x8 CLR: writing clears the written 1-bits in DATA; reads return DATA.
  - +0xC DUTY: read/write, bits [7:0]; upper bits read as 0.
- 0x100 PRESCALE: read/write, 16 bits.
- All other addresses: reads return 0; writes are ignored.
- Byte-lane enables:
  - byte: lane `address[1:0]`.
  - half: lanes {`address[1]`*2, +1}; `address[0]`=1 is misaligned and the write is ignored.
  - word: all lanes; `address[1:0]` must be 0, otherwise the write is ignored.
- SET, CLR, DATA and DUTY act only on enabled lanes.
- DATA bits at or above `WIDTH` are not stored and read as 0.
- Prescaler: a 16-bit counter counts 0..PRESCALE, then wraps to 0 and issues a one-cycle `tick`.
- PWM counter: 8 bits, advances on each `tick`, counts 0..254 and wraps to 0 (period 255 ticks).
- Channel enable `pwm_on[c]` = (pwm_cnt < DUTY[c]). DUTY=255 means always on; DUTY=0 means always off.
- Pin output: `led` channel c <= DATA[c] & {WIDTH{pwm_on[c]}}.
- Reset values:
  - DATA = 0, DUTY = 0xFF, PRESCALE = 0.
  - Prescaler count = 0, pwm_cnt = 0.
  - `led` = 0.
  - After reset, the block behaves as plain output registers.

## Timing
- A write accepted at edge N updates the register at edge N. `output_out` shows the new value in cycle N+1. `led` reflects it at edge N+1 (one extra pipeline register).
- A write to PRESCALE clears the prescaler counter at the same edge. `pwm_cnt` is unaffected.
- With PRESCALE=P, `tick` asserts every P+1 cycles. P=0 gives a tick every cycle.
- A DUTY change takes effect at the next `led` update; there is no period-boundary synchronisation.
- Simultaneous events: only one address is written per cycle, so no intra-block conflicts arise. A write to a channel never disturbs other channels' DATA or DUTY.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first update after `rst_n` rises occurs on the first `clk` edge.

## Structure
- Shared package `output_map_pkg`:
  - register offset constants (`OFS_DATA`, `OFS_SET`, `OFS_CLR`, `OFS_DUTY`, `ADDR_PRESCALE`)
  - `size_e` enum
  - `PWM_MAX` = 254
- Sub-module `pwm_timebase`: prescaler plus PWM counter, with PRESCALE write/clear inputs; outputs `pwm_cnt`.
- Top level: address decode, byte-lane mask generation, per-channel generate loop, `led` register.

## Test plan
- Reset, then word-write 0xA5 to 0x00 → `output_out`=0x000000A5 next cycle; `led`[7:0]=0xA5 one cycle later; other channels stay 0.
- DATA=0xF0, write 0x0F to SET (0x04) then 0x30 to CLR (0x08) → DATA reads 0xFF, then 0xCF.
- Byte-write 0x5A at 0x12 (channel 1, lane 2) with `WIDTH`=32 → ch1 DATA=0x005A0000. Half-write at 0x11 → ignored.
- PRESCALE=0, DUTY[0]=64, DATA[0]=0xFF → `led`[7:0] high for exactly 64 of every 255 cycles. DUTY=0 → never high; DUTY=255 → always high.
- PRESCALE=3 → `tick` every 4 cycles. Rewriting PRESCALE mid-count → counter restarts from 0.
- Assert `rst_n` low mid-PWM → `led`=0 immediately, DUTY reads 0xFF, unmapped 0x200 reads 0.
